// File: rtl/tpu_pkg.sv
// Shared types and helpers for the weight-stationary matrix engine.
// Widths derive from the core's N / DATA_W / ACC_W parameters.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_A,
    COMPUTE,
    DRAIN
  } state_t;

  function automatic int sum_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int compute_cycles(input int n);
    return 3 * n;
  endfunction

  // Saturating add of two sign-extended operands into acc_w bits.
  function automatic logic signed [63:0] sat_val(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 acc_w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic logic sat_hit(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 acc_w
  );
    return sat_val(a, b, acc_w) != a + b;
  endfunction

endpackage

// File: rtl/tpu_core_mac_pe.sv
// One processing element: stationary weight, MAC into the partial sum,
// activation forwarded to the next column.
module mac_pe
  import tpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 17
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w_load,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [DATA_W-1:0] act_in,
  input  logic signed [SUM_W-1:0]  psum_in,
  output logic signed [DATA_W-1:0] act_out,
  output logic signed [SUM_W-1:0]  psum_out
);

  logic signed [DATA_W-1:0]   w_q;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = act_in * w_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q      <= '0;
      act_out  <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) w_q <= w_in;
      act_out  <= act_in;
      psum_out <= psum_in + SUM_W'(prod);
    end
  end

endmodule

// File: rtl/tpu_core.sv
// Job-driven NxN weight-stationary matmul core with streaming
// weight/activation loads and a retained saturating result buffer.
module tpu_core
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                accumulate,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [N*DATA_W-1:0] w_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [N*DATA_W-1:0] a_data,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [N*ACC_W-1:0]  r_data,
  output logic                busy,
  output logic                done,
  output logic                sat_flag
);

  localparam int SUM_W  = sum_width(N, DATA_W);
  localparam int CYCLES = compute_cycles(N);
  localparam int RW     = $clog2(N);
  localparam int CW     = $clog2(CYCLES);

  state_t        state_q, state_d;
  logic [RW-1:0] row_q;
  logic [CW-1:0] cyc_q;
  logic          acc_q, done_q, sat_q;
  logic          row_last, w_fire, a_fire, r_fire;
  logic          any_clamp;

  logic signed [DATA_W-1:0] a_reg    [N][N];
  logic signed [ACC_W-1:0]  c_buf    [N][N];
  logic signed [DATA_W-1:0] act_skew [N];
  logic signed [DATA_W-1:0] act_h    [N][N];
  logic signed [SUM_W-1:0]  psum     [N][N];
  logic signed [63:0]       lhs      [N][N];
  logic signed [63:0]       rhs      [N];
  logic                     wb_en    [N][N];

  assign w_ready  = state_q == LOAD_W;
  assign a_ready  = state_q == LOAD_A;
  assign r_valid  = state_q == DRAIN;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign sat_flag = sat_q;

  assign w_fire   = w_valid && w_ready;
  assign a_fire   = a_valid && a_ready;
  assign r_fire   = r_valid && r_ready;
  assign row_last = row_q == RW'(N - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD_W;
      LOAD_W:  if (w_fire && row_last) state_d = LOAD_A;
      LOAD_A:  if (a_fire && row_last) state_d = COMPUTE;
      COMPUTE: if (cyc_q == CW'(CYCLES - 1)) state_d = DRAIN;
      DRAIN:   if (r_fire && row_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row k enters the array k cycles late so sums meet their activations.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      act_skew[k] = '0;
      for (int i = 0; i < N; i++)
        if (state_q == COMPUTE && cyc_q == CW'(i + k))
          act_skew[k] = a_reg[i][k];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DATA_W-1:0] a_in;
      logic signed [SUM_W-1:0]  p_in;
      if (j == 0) begin : g_a0
        assign a_in = act_skew[k];
      end else begin : g_an
        assign a_in = act_h[k][j-1];
      end
      if (k == 0) begin : g_p0
        assign p_in = '0;
      end else begin : g_pn
        assign p_in = psum[k-1][j];
      end
      mac_pe #(
        .DATA_W(DATA_W),
        .SUM_W (SUM_W)
      ) u_pe (
        .clk     (clk),
        .reset   (reset),
        .w_load  (w_fire && row_q == RW'(k)),
        .w_in    (w_data[j*DATA_W +: DATA_W]),
        .act_in  (a_in),
        .psum_in (p_in),
        .act_out (act_h[k][j]),
        .psum_out(psum[k][j])
      );
    end
    logic unused_tail;
    assign unused_tail = ^act_h[k][N-1];
  end

  // Column j emits row i at compute cycle i+N+j; capture it there.
  always_comb begin
    any_clamp = 1'b0;
    for (int j = 0; j < N; j++)
      rhs[j] = 64'(psum[N-1][j]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        lhs[i][j]   = acc_q ? 64'(c_buf[i][j]) : 64'sd0;
        wb_en[i][j] = state_q == COMPUTE && cyc_q == CW'(i + N + j);
        if (wb_en[i][j] && sat_hit(lhs[i][j], rhs[j], ACC_W))
          any_clamp = 1'b1;
      end
  end

  always_comb begin
    r_data = '0;
    for (int j = 0; j < N; j++)
      r_data[j*ACC_W +: ACC_W] = c_buf[row_q][j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      cyc_q   <= '0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          a_reg[i][k] <= '0;
          c_buf[i][k] <= '0;
        end
    end else begin
      state_q <= state_d;
      done_q  <= state_q == DRAIN && state_d == IDLE;
      cyc_q   <= state_q == COMPUTE ? cyc_q + 1'b1 : '0;
      if (w_fire || a_fire || r_fire)
        row_q <= row_last ? '0 : row_q + 1'b1;
      if (state_q == IDLE && start) begin
        acc_q <= accumulate;
        sat_q <= 1'b0;
      end else if (any_clamp) begin
        sat_q <= 1'b1;
      end
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++)
          if (a_fire && row_q == RW'(i))
            a_reg[i][k] <= a_data[k*DATA_W +: DATA_W];
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (wb_en[i][j])
            c_buf[i][j] <= ACC_W'(sat_val(lhs[i][j], rhs[j], ACC_W));
    end
  end

endmodule

// File: tb/tb_tpu_core.sv
// Bench for tpu_core (N=2): job table with result scoreboard plus
// hand-written backpressure, illegal-input and mid-job reset sequences.
module tb_tpu_core;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 16;

  typedef struct {
    logic [1:0][15:0] w;
    logic [1:0][15:0] a;
    logic             acc;
    logic [1:0][31:0] r;
    logic             sat;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          accumulate = 1'b0;
  logic          w_valid = 1'b0;
  logic          a_valid = 1'b0;
  logic          r_ready = 1'b1;
  logic [N*DW-1:0] w_data = '0;
  logic [N*DW-1:0] a_data = '0;
  logic          w_ready, a_ready, r_valid, busy, done, sat_flag;
  logic [N*AW-1:0] r_data;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   rv_cyc = 0;
  int   t0 = 0;
  int   d0 = 0;
  int   n = 0;
  logic rv_prev = 1'b0;
  logic [31:0] exp_q [$];
  vec_t vecs [5];

  tpu_core #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .accumulate(accumulate),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .busy      (busy),
    .done      (done),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] p8(input int x0, input int x1);
    return {8'(x1), 8'(x0)};
  endfunction

  function automatic logic [31:0] p16(input int x0, input int x1);
    return {16'(x1), 16'(x0)};
  endfunction

  function automatic vec_t mk(
    input logic [15:0] w0, input logic [15:0] w1,
    input logic [15:0] a0, input logic [15:0] a1,
    input logic acc,
    input logic [31:0] r0, input logic [31:0] r1,
    input logic sat
  );
    vec_t x;
    x.w[0] = w0; x.w[1] = w1;
    x.a[0] = a0; x.a[1] = a1;
    x.acc  = acc;
    x.r[0] = r0; x.r[1] = r1;
    x.sat  = sat;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)",
               nm, got, want, cyc);
    end
  endtask

  task automatic start_job(input logic acc);
    start = 1'b1;
    accumulate = acc;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    accumulate = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("sat_cleared_on_start", sat_flag, 0);
  endtask

  task automatic send_w(input logic [15:0] d);
    int k;
    k = 0;
    w_data = d;
    w_valid = 1'b1;
    @(negedge clk);
    while (!w_ready && k < 20) begin @(negedge clk); k++; end
    chk("w_ready", w_ready, 1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic send_a(input logic [15:0] d);
    int k;
    k = 0;
    a_data = d;
    a_valid = 1'b1;
    @(negedge clk);
    while (!a_ready && k < 20) begin @(negedge clk); k++; end
    chk("a_ready", a_ready, 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 200);
    chk(nm, done, 1);
  endtask

  task automatic load_identity();
    send_w(p8(1, 0));
    send_w(p8(0, 1));
  endtask

  initial begin
    vecs[0] = mk(p8(1, 0), p8(0, 1), p8(3, 4), p8(5, 6), 1'b0,
                 p16(3, 4), p16(5, 6), 1'b0);
    vecs[1] = mk(p8(1, 0), p8(0, 1), p8(3, 4), p8(5, 6), 1'b1,
                 p16(6, 8), p16(10, 12), 1'b0);
    vecs[2] = mk(p8(4, 5), p8(6, -7), p8(-2, 3), p8(1, -1), 1'b0,
                 p16(10, -31), p16(-2, 12), 1'b0);
    vecs[3] = mk(p8(-128, 0), p8(-128, 0), p8(-128, -128), p8(0, 0), 1'b0,
                 p16(32767, 0), p16(0, 0), 1'b1);
    vecs[4] = vecs[0];

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (r_valid && !rv_prev) rv_cyc = cyc;
          if (done) done_cnt++;
          if (r_valid && r_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL row_unexpected: got %0h, required no row", r_data);
            end else begin
              chk("row", r_data, exp_q.pop_front());
            end
          end
        end
        rv_prev = r_valid;
      end
      begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got no finish, required finish in 5000 cycles");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_r_data", r_data, 0);

    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].r[0]);
      exp_q.push_back(vecs[v].r[1]);
      start_job(vecs[v].acc);
      for (int k = 0; k < N; k++) send_w(vecs[v].w[k]);
      for (int k = 0; k < N; k++) send_a(vecs[v].a[k]);
      wait_done("job_done");
      chk("rv_latency", rv_cyc - t0, 11);
      chk("done_latency", cyc - t0, 13);
      chk("job_sat", sat_flag, vecs[v].sat);
    end

    // Backpressure, start during COMPUTE, w_valid during LOAD_A.
    exp_q.push_back(p16(3, 4));
    exp_q.push_back(p16(5, 6));
    d0 = done_cnt;
    r_ready = 1'b0;
    start_job(1'b0);
    load_identity();
    w_valid = 1'b1;
    w_data = 16'h7f81;
    send_a(p8(3, 4));
    send_a(p8(5, 6));
    w_valid = 1'b0;
    start = 1'b1;
    accumulate = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    accumulate = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!r_valid && n < 50);
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      chk("stall_valid", r_valid, 1);
      chk("stall_data", r_data, p16(3, 4));
    end
    @(posedge clk); #1;
    r_ready = 1'b1;
    wait_done("stall_done");
    repeat (8) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("idle_after_ignored_start", busy, 0);

    // Reset in the middle of COMPUTE must clear the retained buffer.
    start_job(1'b0);
    load_identity();
    send_a(p8(3, 4));
    send_a(p8(5, 6));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_r_valid", r_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sat", sat_flag, 0);
    chk("mid_rst_r_data", r_data, 0);
    chk("mid_rst_w_ready", w_ready, 0);
    chk("mid_rst_a_ready", a_ready, 0);

    exp_q.push_back(p16(3, 4));
    exp_q.push_back(p16(5, 6));
    start_job(1'b1);
    load_identity();
    send_a(p8(3, 4));
    send_a(p8(5, 6));
    wait_done("post_reset_done");
    chk("post_reset_sat", sat_flag, 0);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_core.md
Name: tpu_core

Overview:
Parametrised NxN weight-stationary matrix-multiply engine. It generalises the fixed 2x2 top level into a single job-driven core with ready/valid streaming for weights, activations and results. It computes C = A x W with signed arithmetic and wide saturating accumulators. An optional accumulate mode (C += A x W) supports K-tiling across jobs. It sits between the memory controller/unified buffer and the instruction sequencer.

Parameters:
N, 2, array dimension (rows = cols = N, N >= 2)
DATA_W, 8, signed activation/weight width
ACC_W, 16, signed result width (ACC_W >= 2*DATA_W)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  job request, sampled only in IDLE
accumulate  in  1  sampled with start; 1 = add into retained result buffer, 0 = overwrite
w_valid  in  1  weight row valid
w_ready  out  1  high only in LOAD_W
w_data  in  N*DATA_W  weight row k; lane j = bits [j*DATA_W +: DATA_W] = W[k][j]
a_valid  in  1  activation row valid
a_ready  out  1  high only in LOAD_A
a_data  in  N*DATA_W  activation row i; lane k = A[i][k]
r_valid  out  1  result row valid (DRAIN)
r_ready  in  1  consumer ready
r_data  out  N*ACC_W  result row i; lane j = C[i][j]
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse at job end
sat_flag  out  1  sticky per job: any lane saturated

Behaviour:
- Reset is synchronous and active-high on clk. It applies in any state, including mid-job. Effects: state -> IDLE; all outputs 0; result buffer, weight/activation registers, counters and sat_flag cleared.
- FSM: IDLE -> LOAD_W -> LOAD_A -> COMPUTE -> DRAIN -> IDLE.
- IDLE: start=1 latches accumulate and clears sat_flag. The next cycle is LOAD_W with busy=1.
- LOAD_W: each w_valid&&w_ready beat stores row k, with k counting 0..N-1. After the N-th beat, the next cycle is LOAD_A. w_valid is ignored in all other states.
- LOAD_A: the same rule applies to a_valid/a_data, with rows i = 0..N-1. After the N-th beat, the next cycle is COMPUTE.
- COMPUTE: lasts exactly 3N cycles regardless of data. This covers input skew (N-1), array propagation (N) and de-skew/writeback; the implementation pads to exactly 3N.
- Arithmetic: C[i][j] = sum over k of A[i][k]*W[k][j], computed exactly (width 2*DATA_W+clog2(N)).
  - If accumulate=1, the stored value becomes sat(old + sum).
  - If accumulate=0, the stored value becomes sat(sum).
  - sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets sat_flag, which holds until the next accepted start or reset.
- DRAIN: r_valid=1 and r_data = row i, starting at i=0.
  - Each r_valid&&r_ready advances i.
  - While r_ready=0, r_data and r_valid are held stable.
  - After the N-th handshake, the next cycle is IDLE with done=1 for one cycle, busy=0, r_valid=0.
- start while busy: ignored, with no queuing.
- accumulate=1 on the first job after reset: adds to zero, so it is identical to overwrite.
- The result buffer is retained across jobs; it is cleared only by reset.
- Latency with no stalls: start accepted at cycle t → first r_valid at t+2N+3N+1 → done at t+5N+N+1. For N=2: r_valid at t+11, done at t+13.

Decomposition:
- Package tpu_pkg:
  - state enum (IDLE, LOAD_W, LOAD_A, COMPUTE, DRAIN)
  - localparams SUM_W = 2*DATA_W+$clog2(N) and COMPUTE_CYCLES = 3*N
  - a saturating-add function parametrised by ACC_W
- One sub-module, mac_pe: holds its weight, performs a signed DATA_W x DATA_W multiply plus a SUM_W partial-sum add, and forwards the activation. It is generated N*N times.
- The skew/de-skew shift registers and the FSM stay in tpu_core.

Test Plan:
1. Identity (N=2): W=[[1,0],[0,1]], A=[[3,4],[5,6]], accumulate=0, r_ready=1 → rows (3,4), (5,6); r_valid first at t+11; done at t+13; sat_flag=0.
2. Signed: W=[[4,5],[6,-7]], A=[[-2,3],[1,-1]] → rows (10,-31), (-2,12).
3. Accumulate: after test 1, rerun the same data with accumulate=1 → rows (6,8), (10,12).
4. Saturation:
   - A=[[-128,-128],[0,0]], W=[[-128,0],[-128,0]] → row0 lane0 = 32767, sat_flag=1, other lanes 0.
   - Then run test 1 with accumulate=0 → sat_flag cleared on start and stays 0.
5. Backpressure/illegal:
   - Hold r_ready=0 for 5 cycles in DRAIN → r_valid=1 and r_data stable throughout.
   - Pulse start during COMPUTE → ignored, exactly one done.
   - w_valid asserted in LOAD_A → no effect on results.
6. Reset mid-job: assert reset for 1 cycle during COMPUTE → next cycle busy=0, all outputs 0. A following job with accumulate=1 on identity data → rows (3,4), (5,6), confirming the buffer was cleared.
